// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the two CPU requesters, the arbiter and the SRAM.
//   Fetch side : inst_req, inst_addr, inst_cancel -> inst_addr_ok,
//                inst_data_ok, inst_rdata
//   Data side  : data_req, data_wr, data_wstrb, data_addr, data_wdata ->
//                data_addr_ok, data_data_ok, data_rdata
//   SRAM side  : sram_en, sram_we, sram_addr, sram_wdata <- sram_rdata
// The slave modport is the arbiter; the master modport is the environment
// (requesters plus SRAM model).
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_cancel;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [31:0]       inst_rdata;

  logic              data_req;
  logic              data_wr;
  logic [3:0]        data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [31:0]       data_rdata;

  logic              sram_en;
  logic [3:0]        sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;

  modport slave (
    input  inst_req, inst_addr, inst_cancel,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output inst_req, inst_addr, inst_cancel,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM (1-cycle read latency) between the
// instruction-fetch and load/store requesters.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset; forces every output to 0
//   bus   - sram_port_arbiter_if.slave: both requester handshakes and the
//           SRAM drive/return signals
// Arbitration favours data; after STARVE_LIMIT consecutive data grants taken
// while fetch was waiting, fetch wins once. One access per cycle, responses
// return the following cycle to the owner recorded at grant time.
module sram_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input logic               clk,
  input logic               reset,
  sram_port_arbiter_if.slave bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Streak counter saturates at the limit so a long data burst cannot wrap it.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= LIMIT) ? LIMIT : v + 4'd1;
  endfunction

  logic [3:0] r_streak;
  logic       r_resp_valid_p1;
  logic       r_resp_inst_p1;

  logic w_inst_live;
  logic w_grant_i;
  logic w_grant_d;
  logic w_grant;
  logic w_resp_i;
  logic w_resp_d;

  // Stage p0: combinational grant and SRAM drive
  always_comb begin
    w_inst_live = bus.inst_req & ~bus.inst_cancel;
    w_grant_i   = ~reset & w_inst_live & (~bus.data_req | (r_streak == LIMIT));
    w_grant_d   = ~reset & bus.data_req & ~w_grant_i;
    w_grant     = w_grant_i | w_grant_d;
  end

  always_comb begin
    bus.inst_addr_ok = w_grant_i;
    bus.data_addr_ok = w_grant_d;
    bus.sram_en      = w_grant;
    bus.sram_we      = 4'd0;
    bus.sram_addr    = {ADDR_W{1'b0}};
    bus.sram_wdata   = 32'd0;
    if (w_grant_i) begin
      bus.sram_addr = bus.inst_addr;
    end else if (w_grant_d) begin
      bus.sram_addr  = bus.data_addr;
      bus.sram_wdata = bus.data_wdata;
      bus.sram_we    = bus.data_wstrb & {4{bus.data_wr}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_streak        <= 4'd0;
      r_resp_valid_p1 <= 1'b0;
      r_resp_inst_p1  <= 1'b0;
    end else begin
      r_resp_valid_p1 <= w_grant;
      if (w_grant)
        r_resp_inst_p1 <= w_grant_i;
      // A cancelled fetch neither resets nor advances the streak.
      if (w_grant_i || !bus.inst_req)
        r_streak <= 4'd0;
      else if (w_grant_d && w_inst_live)
        r_streak <= sat_inc(r_streak);
    end
  end

  // Stage p1: response routing; a redirect in the response cycle drops fetch data
  always_comb begin
    w_resp_i         = ~reset & r_resp_valid_p1 &  r_resp_inst_p1 & ~bus.inst_cancel;
    w_resp_d         = ~reset & r_resp_valid_p1 & ~r_resp_inst_p1;
    bus.inst_data_ok = w_resp_i;
    bus.data_data_ok = w_resp_d;
    bus.inst_rdata   = w_resp_i ? bus.sram_rdata : 32'd0;
    bus.data_rdata   = w_resp_d ? bus.sram_rdata : 32'd0;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;
  localparam int ADDR_W       = 32;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDR_W(ADDR_W)) bus();

  sram_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic        inst;
    logic [31:0] rdata;
  } resp_t;

  resp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.inst_req    = 1'b0;
    bus.inst_addr   = '0;
    bus.inst_cancel = 1'b0;
    bus.data_req    = 1'b0;
    bus.data_wr     = 1'b0;
    bus.data_wstrb  = 4'h0;
    bus.data_addr   = '0;
    bus.data_wdata  = 32'h0;
  endtask

  // One clock cycle: drive SRAM return for any due response, check at the
  // falling edge, record the expected response of this cycle's grant.
  task automatic step(input logic exp_i, input logic exp_d, input logic [31:0] rsp_data);
    resp_t cur;
    logic  have;
    logic  [31:0] exp_addr;
    logic  [31:0] exp_wdata;
    logic  [3:0]  exp_we;
    cur  = '0;
    have = (sb_q.size() > 0);
    if (have) begin
      cur = sb_q.pop_front();
      bus.sram_rdata = cur.rdata;
    end else begin
      bus.sram_rdata = $urandom;
    end
    @(negedge clk);
    if (reset) begin
      chk("rst_inst_addr_ok", 64'(bus.inst_addr_ok), 64'd0);
      chk("rst_data_addr_ok", 64'(bus.data_addr_ok), 64'd0);
      chk("rst_inst_data_ok", 64'(bus.inst_data_ok), 64'd0);
      chk("rst_data_data_ok", 64'(bus.data_data_ok), 64'd0);
      chk("rst_inst_rdata",   64'(bus.inst_rdata),   64'd0);
      chk("rst_data_rdata",   64'(bus.data_rdata),   64'd0);
      chk("rst_sram_en",      64'(bus.sram_en),      64'd0);
      chk("rst_sram_we",      64'(bus.sram_we),      64'd0);
      chk("rst_sram_addr",    64'(bus.sram_addr),    64'd0);
      chk("rst_sram_wdata",   64'(bus.sram_wdata),   64'd0);
    end else begin
      chk("inst_data_ok", 64'(bus.inst_data_ok), 64'(have && cur.inst && !bus.inst_cancel));
      chk("data_data_ok", 64'(bus.data_data_ok), 64'(have && !cur.inst));
      if (have && cur.inst && !bus.inst_cancel) begin
        chk("inst_rdata", 64'(bus.inst_rdata), 64'(cur.rdata));
        chk("data_rdata_idle", 64'(bus.data_rdata), 64'd0);
      end
      if (have && !cur.inst) begin
        chk("data_rdata", 64'(bus.data_rdata), 64'(cur.rdata));
        chk("inst_rdata_idle", 64'(bus.inst_rdata), 64'd0);
      end
      exp_addr  = exp_i ? bus.inst_addr : (exp_d ? bus.data_addr : 32'h0);
      exp_wdata = exp_d ? bus.data_wdata : 32'h0;
      exp_we    = (exp_d && bus.data_wr) ? bus.data_wstrb : 4'h0;
      chk("inst_addr_ok", 64'(bus.inst_addr_ok), 64'(exp_i));
      chk("data_addr_ok", 64'(bus.data_addr_ok), 64'(exp_d));
      chk("sram_en",      64'(bus.sram_en),      64'(exp_i | exp_d));
      chk("sram_addr",    64'(bus.sram_addr),    64'(exp_addr));
      chk("sram_wdata",   64'(bus.sram_wdata),   64'(exp_wdata));
      chk("sram_we",      64'(bus.sram_we),      64'(exp_we));
      if (exp_i || exp_d)
        sb_q.push_back('{inst: exp_i, rdata: rsp_data});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    bus.sram_rdata = 32'h0;
    @(posedge clk);
    #1;

    // Reset: outputs held at zero even with requests present
    bus.inst_req  = 1'b1; bus.inst_addr = 32'h1c000000;
    bus.data_req  = 1'b1; bus.data_addr = 32'h1c008000;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    idle_inputs();
    reset = 1'b0;
    step(1'b0, 1'b0, 32'h0);

    // Single fetch
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1c000000;
    step(1'b1, 1'b0, 32'h02800c0c);
    idle_inputs();
    step(1'b0, 1'b0, 32'h0);

    // Conflict: load wins over fetch; full wstrb on a load must not write
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1c000004;
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_wstrb = 4'hf;
    bus.data_addr = 32'h1c008000; bus.data_wdata = 32'hdeadbeef;
    step(1'b0, 1'b1, 32'h11223344);
    idle_inputs();
    step(1'b0, 1'b0, 32'h0);

    // Starvation guard with both requests held: D D D D I D D D D I
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1c000010;
    bus.data_req = 1'b1; bus.data_addr = 32'h1c008010;
    for (int i = 1; i <= 10; i++)
      step((i % 5) == 0, (i % 5) != 0, $urandom);
    idle_inputs();
    step(1'b0, 1'b0, 32'h0);

    // Byte store
    bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_wstrb = 4'h4;
    bus.data_addr = 32'h1c008002; bus.data_wdata = 32'h00ab0000;
    step(1'b0, 1'b1, 32'h5a5a5a5a);
    idle_inputs();
    step(1'b0, 1'b0, 32'h0);

    // Cancel in the response cycle drops the read; cancel also blocks a new fetch grant
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1c000020;
    step(1'b1, 1'b0, 32'hcafef00d);
    bus.inst_cancel = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    idle_inputs();
    step(1'b0, 1'b0, 32'h0);

    // Cancelled fetch alongside a store: data still proceeds
    bus.inst_req = 1'b1; bus.inst_cancel = 1'b1; bus.inst_addr = 32'h1c000024;
    bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_wstrb = 4'h3;
    bus.data_addr = 32'h1c00800c; bus.data_wdata = 32'h0000beef;
    step(1'b0, 1'b1, 32'h01020304);
    idle_inputs();
    step(1'b0, 1'b0, 32'h0);

    // Reset mid-op: fetch granted, then reset in its response cycle
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1c000030;
    step(1'b1, 1'b0, 32'h87654321);
    reset = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    idle_inputs();
    step(1'b0, 1'b0, 32'h0);

    // Build a streak of 3, reset, then confirm the streak restarted at 0
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1c000040;
    bus.data_req = 1'b1; bus.data_addr = 32'h1c008040;
    step(1'b0, 1'b1, $urandom);
    step(1'b0, 1'b1, $urandom);
    step(1'b0, 1'b1, $urandom);
    reset = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    step(1'b0, 1'b1, $urandom);
    step(1'b0, 1'b1, $urandom);
    step(1'b0, 1'b1, $urandom);
    step(1'b0, 1'b1, $urandom);
    step(1'b1, 1'b0, $urandom);
    idle_inputs();
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one synchronous single-port SRAM between the instruction-fetch requester and the load/store requester of the CPU core.
- Each requester uses a req/addr_ok/data_ok handshake.
- Arbitration is data-priority with a starvation guard for fetch. Reads return after a fixed one-cycle SRAM latency.
- Supports fetch-response cancellation on branch redirect.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive data grants while fetch is waiting before fetch is forced through (1..15).
- ADDR_W, 32: address width of requesters and SRAM.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- inst_req  input  1  fetch request valid
- inst_addr  input  ADDR_W  fetch address
- inst_cancel  input  1  discard fetch grant/response this cycle (redirect)
- inst_addr_ok  output  1  fetch request accepted this cycle
- inst_data_ok  output  1  fetch read data valid
- inst_rdata  output  32  fetch read data
- data_req  input  1  load/store request valid
- data_wr  input  1  1 = store, 0 = load
- data_wstrb  input  4  byte enables for stores
- data_addr  input  ADDR_W  load/store address
- data_wdata  input  32  store data
- data_addr_ok  output  1  load/store request accepted this cycle
- data_data_ok  output  1  load data valid / store completed
- data_rdata  output  32  load data
- sram_en  output  1  SRAM access enable
- sram_we  output  4  SRAM byte write enables
- sram_addr  output  ADDR_W  SRAM address
- sram_wdata  output  32  SRAM write data
- sram_rdata  input  32  SRAM read data, valid the cycle after sram_en

Behaviour:
- Reset: synchronous, active-high, on clk rising edge. While reset=1 every output is 0; addr_ok outputs are gated by ~reset. After reset, streak_cnt=0, resp_valid=0, resp_owner=DATA.
- Grant (combinational, same cycle as req):
  - Only data_req=1: grant data.
  - Only inst_req=1 and inst_cancel=0: grant inst.
  - Both: grant inst if streak_cnt==STARVE_LIMIT, else grant data.
  - inst_cancel=1 blocks any fetch grant that cycle; data may still be granted.
- At most one grant per cycle. The granted requester sees addr_ok=1; a handshake completes on req & addr_ok.
- SRAM drive:
  - sram_en = any grant.
  - sram_addr / sram_wdata come from the granted requester.
  - sram_we = data_wstrb & {4{data_wr}} on a data grant, else 0.
  - When no grant, sram_addr and sram_wdata are 0.
- Response pipeline:
  - On a grant, resp_valid<=1 and resp_owner<=winner; otherwise resp_valid<=0.
  - In the next cycle, data_ok=1 to the owner only. The owner's rdata = sram_rdata; the other rdata = 0.
  - A store also gets data_data_ok; its data_rdata is don't-care but is driven with sram_rdata.
- Back-to-back: a new grant may be issued in the same cycle a response returns, giving throughput of one access per cycle. Requesters must accept data_ok unconditionally; there is no response backpressure.
- Cancel: inst_cancel=1 in the response cycle of a fetch forces inst_data_ok=0. The read is lost, and no later response is produced for it.
- Starvation counter:
  - streak_cnt increments (saturating at STARVE_LIMIT) on each data grant while inst_req=1 and inst_cancel=0.
  - It clears to 0 on any inst grant, or in any cycle with inst_req=0.
- Wrap/width: addresses are passed through unmodified; the block does no alignment checking.
- Reset mid-operation: a pending response is dropped. No data_ok is issued in the cycle after reset deasserts unless a new grant occurred in the first non-reset cycle.

Test Plan:
- Single fetch: inst_req=1, addr=0x1c000000 for 1 cycle. Expect inst_addr_ok=1, sram_en=1, sram_we=0. Next cycle, with sram_rdata=0x02800c0c, expect inst_data_ok=1, inst_rdata=0x02800c0c, data_data_ok=0.
- Conflict: inst_req and data_req (load, 0x1c008000) both high. Expect data_addr_ok=1, inst_addr_ok=0; data_data_ok follows next cycle.
- Starvation, STARVE_LIMIT=4: both requests held continuously. Expect grants D,D,D,D,I,D,D,D,D,I…, with inst_addr_ok on cycles 5 and 10.
- Byte store: data_wr=1, wstrb=0x4, addr=0x1c008002, wdata=0x00ab0000. Expect sram_we=0x4, sram_addr=0x1c008002, and data_data_ok the next cycle.
- Cancel: a fetch is granted, then inst_cancel=1 in the response cycle. Expect inst_data_ok=0. Also, inst_cancel=1 together with inst_req=1 and data_req=0 gives inst_addr_ok=0 and sram_en=0.
- Reset mid-op: a fetch is granted, then reset=1 in the response cycle. Expect every output 0 and no data_ok after reset releases; streak_cnt reads back as 0, shown by a conflict granting data first.
